// File: rtl/scoreboard_checker.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_checker
// Purpose  : Multi-channel in-order result checker. Each channel queues
//            expected values in a small FIFO. Each arriving actual result is
//            compared against the oldest queued value under a shared bit mask,
//            and the outcome is tallied in saturating pass/fail counters.
//            A global IDLE/RUN/DRAIN/DONE sequence frames a test run.
// Ports    : clk, rst_n            - clock, async active-low reset
//            start, finish         - run framing pulses
//            exp_valid/data/ready  - per-channel expected-value push
//            act_valid/data        - per-channel actual-result strobe
//            cmp_mask              - shared compare mask (1 = compare bit)
//            pass_cnt, fail_cnt    - packed per-channel counters
//            orphan, leftover      - sticky per-channel error flags
//            state, done, all_pass - run status
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_checker #(
    parameter int WIDTH        = 32,
    parameter int CHANNELS     = 3,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      finish,
    input  logic [CHANNELS-1:0]       exp_valid,
    input  logic [CHANNELS*WIDTH-1:0] exp_data,
    output logic [CHANNELS-1:0]       exp_ready,
    input  logic [CHANNELS-1:0]       act_valid,
    input  logic [CHANNELS*WIDTH-1:0] act_data,
    input  logic [WIDTH-1:0]          cmp_mask,
    output logic [CHANNELS*CNT_W-1:0] pass_cnt,
    output logic [CHANNELS*CNT_W-1:0] fail_cnt,
    output logic [CHANNELS-1:0]       orphan,
    output logic [CHANNELS-1:0]       leftover,
    output logic [1:0]                state,
    output logic                      done,
    output logic                      all_pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]   c_DEPTH      = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] c_DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DW-1:0]       r_drain_cnt;
    logic                w_act_en;
    logic                w_timeout;
    logic                w_all_empty;
    logic [CHANNELS-1:0] w_nonempty;
    logic [CHANNELS-1:0] w_fail_nz;

    assign w_act_en    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    // Timeout fires on the last permitted DRAIN cycle, so DONE is entered
    // after exactly DRAIN_CYCLES cycles in DRAIN.
    assign w_timeout   = (r_state == ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
    assign w_all_empty = ~|w_nonempty;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_RUN:   if (finish) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_all_empty || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        // start restarts from any state and overrides a concurrent finish
        if (start) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (start || (r_state != ST_DRAIN)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    assign state    = r_state;
    assign done     = (r_state == ST_DONE);
    assign all_pass = (r_state == ST_DONE) && ~|w_fail_nz && ~|orphan && ~|leftover;

    // ------------------------------------------------------- per channel
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wr;
        logic [AW-1:0]    r_rd;
        logic [AW:0]      r_count;
        logic [AW:0]      w_count_nxt;
        logic [CNT_W-1:0] r_pass;
        logic [CNT_W-1:0] r_fail;
        logic             r_orphan;
        logic             r_leftover;
        logic             w_ready;
        logic             w_push;
        logic             w_accept;
        logic             w_pop;
        logic             w_orphan_hit;
        logic             w_match;

        assign w_ready      = (r_state == ST_RUN) && (r_count < c_DEPTH);
        assign w_push       = exp_valid[i] && w_ready;
        assign w_accept     = act_valid[i] && w_act_en;
        assign w_pop        = w_accept && (r_count != '0);
        assign w_orphan_hit = w_accept && (r_count == '0);
        // Compare against the pre-push head; a same-cycle push lands behind it.
        assign w_match      = ((act_data[i*WIDTH +: WIDTH] ^ r_mem[r_rd]) & cmp_mask) == '0;

        always_comb begin
            w_count_nxt = r_count;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end

        // Storage is not reset; validity is tracked by the pointers and count.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= exp_data[i*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr       <= '0;
                r_rd       <= '0;
                r_count    <= '0;
                r_pass     <= '0;
                r_fail     <= '0;
                r_orphan   <= 1'b0;
                r_leftover <= 1'b0;
            end else if (start) begin
                r_wr       <= '0;
                r_rd       <= '0;
                r_count    <= '0;
                r_pass     <= '0;
                r_fail     <= '0;
                r_orphan   <= 1'b0;
                r_leftover <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                r_count <= w_count_nxt;
                if (w_pop && w_match && (r_pass != '1)) begin
                    r_pass <= r_pass + 1'b1;
                end
                if (((w_pop && !w_match) || w_orphan_hit) && (r_fail != '1)) begin
                    r_fail <= r_fail + 1'b1;
                end
                if (w_orphan_hit) begin
                    r_orphan <= 1'b1;
                end
                if (w_timeout && (w_count_nxt != '0)) begin
                    r_leftover <= 1'b1;
                end
            end
        end

        assign exp_ready[i]                = w_ready;
        assign pass_cnt[i*CNT_W +: CNT_W]  = r_pass;
        assign fail_cnt[i*CNT_W +: CNT_W]  = r_fail;
        assign orphan[i]                   = r_orphan;
        assign leftover[i]                 = r_leftover;
        assign w_nonempty[i]               = (r_count != '0);
        assign w_fail_nz[i]                = (r_fail != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_checker
// Purpose  : Directed self-checking bench for scoreboard_checker with
//            CHANNELS=3, WIDTH=32, DEPTH=4, DRAIN_CYCLES=8, CNT_W=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_checker;

    localparam int WIDTH = 32;
    localparam int CH    = 3;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  finish;
    logic [CH-1:0]         exp_valid;
    logic [CH*WIDTH-1:0]   exp_data;
    logic [CH-1:0]         exp_ready;
    logic [CH-1:0]         act_valid;
    logic [CH*WIDTH-1:0]   act_data;
    logic [WIDTH-1:0]      cmp_mask;
    logic [CH*CNT_W-1:0]   pass_cnt;
    logic [CH*CNT_W-1:0]   fail_cnt;
    logic [CH-1:0]         orphan;
    logic [CH-1:0]         leftover;
    logic [1:0]            state;
    logic                  done;
    logic                  all_pass;

    int total = 0;
    int bad   = 0;

    scoreboard_checker #(
        .WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(4), .CNT_W(CNT_W), .DRAIN_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .act_valid(act_valid), .act_data(act_data), .cmp_mask(cmp_mask),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .orphan(orphan),
        .leftover(leftover), .state(state), .done(done), .all_pass(all_pass)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] v);
        exp_valid[ch] = 1'b1;
        exp_data[ch*WIDTH +: WIDTH] = v;
        tick();
        exp_valid[ch] = 1'b0;
    endtask

    task automatic act(input int ch, input logic [WIDTH-1:0] v);
        act_valid[ch] = 1'b1;
        act_data[ch*WIDTH +: WIDTH] = v;
        tick();
        act_valid[ch] = 1'b0;
    endtask

    function automatic logic [CNT_W-1:0] pc(input int ch);
        return pass_cnt[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] fc(input int ch);
        return fail_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (exp_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", exp_ready); end
        total++; if (done !== 1'b0 || all_pass !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b want=00", done, all_pass); end
        total++; if (pass_cnt !== '0 || fail_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%h/%h want=0", pass_cnt, fail_cnt); end
        rst_n = 1'b1;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", state); end
    endtask

    task automatic test_basic();
        int k;
        do_start();
        total++; if (state !== 2'd1 || exp_ready !== 3'b111) begin bad++; $display("FAIL run_entry got=%0d/%b want=1/111", state, exp_ready); end
        push(0, 32'd5);
        push(0, 32'd7);
        act(0, 32'd5);
        act(0, 32'd7);
        do_finish();
        k = 0;
        while (!done && k < 2) begin tick(); k++; end
        total++; if (done !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL basic_done got=%b/%0d want=1/3", done, state); end
        total++; if (pc(0) !== 16'd2 || fc(0) !== 16'd0) begin bad++; $display("FAIL basic_cnt got=%0d/%0d want=2/0", pc(0), fc(0)); end
        total++; if (all_pass !== 1'b1) begin bad++; $display("FAIL basic_all_pass got=%b want=1", all_pass); end
    endtask

    task automatic test_full();
        do_start();
        for (int j = 0; j < 4; j++) push(1, 32'h10 + j);
        total++; if (exp_ready[1] !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", exp_ready[1]); end
        total++; if (exp_ready[0] !== 1'b1) begin bad++; $display("FAIL full_indep got=%b want=1", exp_ready[0]); end
        push(1, 32'h99);
        for (int j = 0; j < 4; j++) act(1, 32'h10 + j);
        total++; if (pc(1) !== 16'd4 || fc(1) !== 16'd0) begin bad++; $display("FAIL full_cnt got=%0d/%0d want=4/0", pc(1), fc(1)); end
        total++; if (exp_ready[1] !== 1'b1) begin bad++; $display("FAIL full_ready_again got=%b want=1", exp_ready[1]); end
        // dropped 5th push means the FIFO is now empty: next act is orphan
        act(1, 32'h99);
        total++; if (orphan[1] !== 1'b1 || fc(1) !== 16'd1) begin bad++; $display("FAIL full_drop got=%b/%0d want=1/1", orphan[1], fc(1)); end
    endtask

    task automatic test_mask();
        do_start();
        cmp_mask = 32'h0000FFFF;
        push(0, 32'h1234ABCD);
        push(0, 32'h1234ABCD);
        act(0, 32'hFFFFABCD);
        total++; if (pc(0) !== 16'd1 || fc(0) !== 16'd0) begin bad++; $display("FAIL mask_pass got=%0d/%0d want=1/0", pc(0), fc(0)); end
        act(0, 32'h1234ABCE);
        total++; if (pc(0) !== 16'd1 || fc(0) !== 16'd1) begin bad++; $display("FAIL mask_fail got=%0d/%0d want=1/1", pc(0), fc(0)); end
        cmp_mask = 32'hFFFFFFFF;
    endtask

    task automatic test_orphan();
        do_start();
        exp_valid[2] = 1'b1;
        exp_data[2*WIDTH +: WIDTH] = 32'd9;
        act_valid[2] = 1'b1;
        act_data[2*WIDTH +: WIDTH] = 32'd9;
        tick();
        exp_valid[2] = 1'b0;
        act_valid[2] = 1'b0;
        total++; if (orphan !== 3'b100 || fc(2) !== 16'd1) begin bad++; $display("FAIL orphan_flag got=%b/%0d want=100/1", orphan, fc(2)); end
        act(2, 32'd9);
        total++; if (pc(2) !== 16'd1 || fc(2) !== 16'd1) begin bad++; $display("FAIL orphan_stored got=%0d/%0d want=1/1", pc(2), fc(2)); end
    endtask

    task automatic test_drain_timeout();
        int n;
        do_start();
        push(0, 32'd1);
        push(0, 32'd2);
        push(0, 32'd3);
        do_finish();
        n = 0;
        while (state == 2'd2 && n < 20) begin tick(); n++; end
        total++; if (n !== 8 || state !== 2'd3) begin bad++; $display("FAIL drain_cycles got=%0d/%0d want=8/3", n, state); end
        total++; if (leftover !== 3'b001 || all_pass !== 1'b0) begin bad++; $display("FAIL drain_leftover got=%b/%b want=001/0", leftover, all_pass); end
        act(0, 32'd1);
        tick();
        total++; if (pc(0) !== 16'd0 || fc(0) !== 16'd0 || done !== 1'b1) begin bad++; $display("FAIL done_hold got=%0d/%0d/%b want=0/0/1", pc(0), fc(0), done); end
    endtask

    task automatic test_reset_midrun();
        do_start();
        for (int j = 0; j < 3; j++) push(0, 32'hA0 + j);
        for (int j = 0; j < 3; j++) act(0, 32'hA0 + j);
        total++; if (pc(0) !== 16'd3) begin bad++; $display("FAIL pre_reset_cnt got=%0d want=3", pc(0)); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (state !== 2'd0 || pass_cnt !== '0 || exp_ready !== 3'b000) begin bad++; $display("FAIL async_reset got=%0d/%h/%b want=0/0/000", state, pass_cnt, exp_ready); end
        rst_n = 1'b1;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL post_reset_idle got=%0d want=0", state); end
        start  = 1'b1;
        finish = 1'b1;
        tick();
        start  = 1'b0;
        finish = 1'b0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL start_wins got=%0d want=1", state); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        exp_valid = '0;
        exp_data  = '0;
        act_valid = '0;
        act_data  = '0;
        cmp_mask  = 32'hFFFFFFFF;
        #3;
        test_reset();
        test_basic();
        test_full();
        test_mask();
        test_orphan();
        test_drain_timeout();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scoreboard_checker.md
SCOREBOARD_CHECKER -- requirements
Module: scoreboard_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width of each channel.
REQ-002 The block SHALL have parameter CHANNELS, default 3: number of independent compare channels.
REQ-003 The block SHALL have parameter DEPTH, default 8: expected-value FIFO entries per channel, a power of two and at least 2.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of each pass/fail counter.
REQ-005 The block SHALL have parameter DRAIN_CYCLES, default 64: maximum number of cycles spent in DRAIN.
REQ-006 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-007 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port start  input  1  pulse; clears all channel state and enters RUN.
REQ-009 The block SHALL have port finish  input  1  pulse; no further expected data, enter DRAIN.
REQ-010 The block SHALL have port exp_valid  input  CHANNELS  per-channel expected-value push request.
REQ-011 The block SHALL have port exp_data  input  CHANNELS*WIDTH  expected values, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port exp_ready  output  CHANNELS  per-channel push-accept indication.
REQ-013 The block SHALL have port act_valid  input  CHANNELS  per-channel actual-result strobe.
REQ-014 The block SHALL have port act_data  input  CHANNELS*WIDTH  actual results, packed as exp_data.
REQ-015 The block SHALL have port cmp_mask  input  WIDTH  compare mask shared by all channels; a 1 bit means the bit is compared.
REQ-016 The block SHALL have port pass_cnt  output  CHANNELS*CNT_W  per-channel pass counts.
REQ-017 The block SHALL have port fail_cnt  output  CHANNELS*CNT_W  per-channel fail counts.
REQ-018 The block SHALL have port orphan  output  CHANNELS  sticky flag: a result arrived while that channel's FIFO was empty.
REQ-019 The block SHALL have port leftover  output  CHANNELS  sticky flag: the FIFO was non-empty when DRAIN timed out.
REQ-020 The block SHALL have port state  output  2  current state encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-021 The block SHALL have port done  output  1  high while in DONE.
REQ-022 The block SHALL have port all_pass  output  1  high in DONE when every fail_cnt is 0 and no orphan or leftover flag is set.

Function
REQ-023 The block SHALL make transitions IDLE->RUN on start, RUN->DRAIN on finish, and DRAIN->DONE when all FIFOs are empty or DRAIN_CYCLES cycles have elapsed in DRAIN.
REQ-024 The block SHALL, on start in any state, clear counters, flags and FIFOs and enter RUN on the next edge; start wins over a simultaneous finish.
REQ-025 The block SHALL drive exp_ready[i] = (state==RUN) && (FIFO i count < DEPTH).
REQ-026 The block SHALL push exp_data[i] into FIFO i only on a cycle where exp_valid[i] and exp_ready[i] are both high; exp_valid while exp_ready is low is dropped.
REQ-027 The block SHALL accept act_valid only in RUN and DRAIN; in IDLE and DONE it is ignored.
REQ-028 The block SHALL, on an accepted act_valid[i] with FIFO i non-empty, pop the head and evaluate ((act ^ head) & cmp_mask) == 0: true increments pass_cnt[i], false increments fail_cnt[i].
REQ-029 The block SHALL, on an accepted act_valid[i] with FIFO i empty, increment fail_cnt[i] and set orphan[i]; this applies even if a push occurs in the same cycle (the push is still stored).
REQ-030 The block SHALL, on a simultaneous push and pop on a non-empty FIFO, perform both and leave the count unchanged; the pop uses the pre-push head.
REQ-031 The block SHALL make counter updates visible on the rising edge after the accepting cycle (1-cycle latency).
REQ-032 The block SHALL saturate counters at 2^CNT_W-1, never wrapping.
REQ-033 The block SHALL wrap FIFO pointers modulo DEPTH; occupancy SHALL be exact for 0..DEPTH.
REQ-034 The block SHALL, on DRAIN timeout, set leftover[i] for every non-empty FIFO i; the remaining entries are not counted.
REQ-035 The block SHALL hold all counters and flags stable in DONE until start or reset.
REQ-036 The block SHALL keep channels fully independent; activity on one channel never affects another.

Reset
REQ-037 The block SHALL, while rst_n is low, asynchronously force state=IDLE, all counters 0, orphan/leftover 0, FIFOs empty, exp_ready 0, done 0 and all_pass 0.
REQ-038 The block SHALL, on reset asserted mid-RUN or mid-DRAIN, discard all in-flight data; after release it is IDLE and waits for start.

Verification (CHANNELS=3, WIDTH=32, DEPTH=4, DRAIN_CYCLES=8, cmp_mask=FFFFFFFF unless stated)
REQ-039 The bench SHALL check: start; push 5,7 on ch0; act 5,7; finish -> DONE within 2 cycles, pass_cnt0=2, fail_cnt0=0, all_pass=1.
REQ-040 The bench SHALL check: push 4 values on ch1 -> exp_ready1=0; 5th push dropped; act 4 matching values -> pass_cnt1=4, exp_ready1=1 again.
REQ-041 The bench SHALL check: cmp_mask=0000FFFF; exp 0x1234ABCD, act 0xFFFFABCD -> pass; act 0x1234ABCE -> fail_cnt incremented.
REQ-042 The bench SHALL check: act on ch2 with empty FIFO and simultaneous push of 9 -> orphan2=1, fail_cnt2=1, FIFO2 holds 9.
REQ-043 The bench SHALL check: push 3 values on ch0, finish, no act -> DONE after 8 DRAIN cycles, leftover0=1, all_pass=0.
REQ-044 The bench SHALL check: rst_n low mid-RUN with pass_cnt0=3 -> immediate state=0, counters 0; start with finish in the same cycle -> state=RUN.
